ksa_multiword_seq: RTL

- Sequences a single 16-bit KoggeStoneAdder instance over NWORDS clock cycles to add or subtract two operands of 16*NWORDS bits.
- The carry is chained word by word, least-significant word first.
- Sits between a requesting unit (start/done handshake) and the shared 16-bit adder, so wide arithmetic needs no wider adder.
- The instance port order is (sum[16:0], a, b, cin). It is the only adder in the block.

---
 rtl/ksa_multiword_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ksa_multiword_seq.sv
// ---------------------------------------------------------------------------
// ksa_multiword_seq
//   Runs wide add/subtract over 16*NWORDS-bit operands on one shared 16-bit
//   Kogge-Stone adder. It processes one word per clock, least-significant
//   word first, and passes the carry from one word to the next.
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     start    request, sampled only while idle (busy=0)
//     abort    cancel the operation in flight (no done, outputs kept)
//     sub      0: a+b+cin   1: a-b
//     cin      carry-in for add, ignored for subtract
//     a, b     W-bit operands
//     busy     operation in flight
//     done     one-cycle completion pulse
//     sum      W-bit result, updated only at completion
//     cout     final carry-out (subtract: 1 = no borrow)
//     overflow signed two's-complement overflow of the W-bit result
//
//   State | Meaning
//   IDLE  | waiting for start; outputs hold the last completed result
//   RUN   | one word added per cycle; index selects the word
// ---------------------------------------------------------------------------
module ksa_multiword_seq #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [16*NWORDS-1:0]   a,
    input  logic [16*NWORDS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [16*NWORDS-1:0]   sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W     = 16 * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q;
    logic [W-1:0]       a_q, b_q, work_q, work_d, sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q, done_q, cout_q, ovf_q;
    logic [15:0]        a_word, b_word;
    logic [16:0]        add_sum;
    logic               last_word;

    assign a_word    = a_q[{idx_q, 4'b0000} +: 16];
    assign b_word    = b_q[{idx_q, 4'b0000} +: 16];
    assign last_word = (idx_q == IDX_W'(NWORDS - 1));

    KoggeStoneAdder u_adder (
        .sum (add_sum),
        .a   (a_word),
        .b   (b_word),
        .cin (carry_q)
    );

    // Work vector with the current word merged in. On the last word this is
    // the complete result, so sum can load it in the same edge.
    always_comb begin
        work_d = work_q;
        work_d[{idx_q, 4'b0000} +: 16] = add_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        a_q     <= a;
                        // Subtract is a + ~b + 1, so b is inverted at capture.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        work_q  <= work_d;
                        carry_q <= add_sum[16];
                        if (last_word) begin
                            sum_q   <= work_d;
                            cout_q  <= add_sum[16];
                            // b_q already holds the effective operand; the
                            // result msb is bit 15 of the final word.
                            ovf_q   <= (a_q[W-1] == b_q[W-1]) &&
                                       (add_sum[15] != a_q[W-1]);
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// ---------------------------------------------------------------------------
// KoggeStoneAdder
//   16-bit parallel-prefix adder.
//   Ports: sum[16:0] (sum[16] = carry-out), a, b, cin.
// ---------------------------------------------------------------------------
module KoggeStoneAdder (
    output logic [16:0] sum,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);

    logic [4:0][15:0] g;
    logic [4:0][15:0] p;
    logic [16:0]      c;

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    genvar lv, i;
    generate
        for (lv = 1; lv <= 4; lv++) begin : g_level
            localparam int D = 1 << (lv - 1);
            for (i = 0; i < 16; i++) begin : g_bit
                if (i >= D) begin : g_comb
                    assign g[lv][i] = g[lv-1][i] | (p[lv-1][i] & g[lv-1][i-D]);
                    assign p[lv][i] = p[lv-1][i] & p[lv-1][i-D];
                end else begin : g_pass
                    assign g[lv][i] = g[lv-1][i];
                    assign p[lv][i] = p[lv-1][i];
                end
            end
        end
    endgenerate

    // After four levels, g/p cover bits [i:0], so cin is folded in last.
    assign c[0] = cin;
    generate
        for (i = 0; i < 16; i++) begin : g_carry
            assign c[i+1] = g[4][i] | (p[4][i] & cin);
        end
    endgenerate

    assign sum = {c[16], p[0] ^ c[15:0]};

endmodule
